// File: rtl/ram_stream_dma_if.sv
// Handshake, stream and RAM-port bundle for ram_stream_dma.
// The master modport is the DMA engine's view; slave is the surrounding system.
interface ram_stream_dma_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  start;
  logic                  ready;
  logic                  done;
  logic                  mode;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [ADDR_WIDTH-1:0] length;

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;

  logic [ADDR_WIDTH-1:0] ram_raddr_0;
  logic [DATA_WIDTH-1:0] ram_rdata_0;
  logic [ADDR_WIDTH-1:0] ram_waddr_0;
  logic                  ram_wen_0;
  logic [DATA_WIDTH-1:0] ram_wdata_0;

  modport master (
    input  start, mode, base_addr, length,
    input  in_valid, in_data, out_ready, ram_rdata_0,
    output ready, done, in_ready, out_valid, out_data,
    output ram_raddr_0, ram_waddr_0, ram_wen_0, ram_wdata_0
  );

  modport slave (
    output start, mode, base_addr, length,
    output in_valid, in_data, out_ready, ram_rdata_0,
    input  ready, done, in_ready, out_valid, out_data,
    input  ram_raddr_0, ram_waddr_0, ram_wen_0, ram_wdata_0
  );
endinterface

// File: rtl/ram_stream_dma.sv
// Single-channel DMA moving words between a streaming port and a 1R/1W RAM.
// LOAD writes the inbound stream to RAM; DRAIN reads RAM out one word per 3 cycles.
module ram_stream_dma #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  ram_stream_dma_if.master bus
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD     = 3'd1;
  localparam logic [2:0] S_RD_ISSUE = 3'd2;
  localparam logic [2:0] S_RD_WAIT  = 3'd3;
  localparam logic [2:0] S_RD_OUT   = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] len_q, len_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  last_word;

  // Address wraps modulo 2^ADDR_WIDTH by construction of the adder width.
  assign addr      = base_q + cnt_q;
  assign last_word = (cnt_q == len_q - ADDR_WIDTH'(1));

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          base_d = bus.base_addr;
          len_d  = bus.length;
          cnt_d  = '0;
          if (bus.length == '0)  state_d = S_DONE;
          else if (bus.mode)     state_d = S_RD_ISSUE;
          else                   state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (bus.in_valid) begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
          if (last_word) state_d = S_DONE;
        end
      end
      S_RD_ISSUE: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        out_data_d = bus.ram_rdata_0;
        state_d    = S_RD_OUT;
      end
      S_RD_OUT: begin
        if (bus.out_ready) begin
          cnt_d   = cnt_q + ADDR_WIDTH'(1);
          state_d = last_word ? S_DONE : S_RD_ISSUE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
    end
  end

  assign bus.ready       = (state_q == S_IDLE) || (state_q == S_DONE);
  assign bus.done        = (state_q == S_DONE);
  assign bus.in_ready    = (state_q == S_LOAD);
  assign bus.out_valid   = (state_q == S_RD_OUT);
  assign bus.out_data    = out_data_q;
  assign bus.ram_raddr_0 = addr;
  assign bus.ram_waddr_0 = addr;
  assign bus.ram_wdata_0 = bus.in_data;
  assign bus.ram_wen_0   = (state_q == S_LOAD) && bus.in_valid;

endmodule
